// File: rtl/uart_frame_tx.sv
// Frame-level UART transmit sequencer: sends HEADER, four payload bytes MSB first,
// then an additive checksum, pacing strobes to uart_bus with an internal byte-time counter.
module uart_frame_tx #(
  parameter int unsigned BPS_PARA = 1250,
  parameter logic [7:0]  HEADER   = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic [31:0] frame_data,
  output logic        busy,
  output logic        frame_done,
  output logic        tx_data_valid,
  output logic [7:0]  tx_data_in
);

  localparam int unsigned BYTE_CYCLES = BPS_PARA * 11;
  localparam int unsigned GAP_W       = $clog2(BYTE_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(BYTE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

  state_t           state;
  logic [31:0]      word;
  logic [2:0]       idx;
  logic [GAP_W-1:0] gap;
  logic [7:0]       checksum;
  logic [7:0]       cur_byte;

  always_comb begin
    checksum = word[31:24] + word[23:16] + word[15:8] + word[7:0];
  end

  always_comb begin
    cur_byte = checksum;
    case (idx)
      3'd0:    cur_byte = HEADER;
      3'd1:    cur_byte = word[31:24];
      3'd2:    cur_byte = word[23:16];
      3'd3:    cur_byte = word[15:8];
      3'd4:    cur_byte = word[7:0];
      default: cur_byte = checksum;
    endcase
  end

  // Outputs are registered from the current state, so they lag the state by one cycle;
  // busy therefore covers SEND through DONE exactly one cycle later than the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      word          <= '0;
      idx           <= '0;
      gap           <= '0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      tx_data_valid <= 1'b0;
      tx_data_in    <= '0;
    end else begin
      tx_data_valid <= 1'b0;
      frame_done    <= 1'b0;
      busy          <= (state != IDLE);
      case (state)
        IDLE: begin
          if (frame_start) begin
            word  <= frame_data;
            idx   <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          tx_data_valid <= 1'b1;
          tx_data_in    <= cur_byte;
          gap           <= '0;
          state         <= WAIT;
        end
        WAIT: begin
          if (gap == GAP_LAST) begin
            if (idx < 3'd5) begin
              idx   <= idx + 3'd1;
              state <= SEND;
            end else begin
              state <= DONE;
            end
          end else begin
            gap <= gap + 1'b1;
          end
        end
        DONE: begin
          frame_done <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Scoreboard bench for uart_frame_tx with BPS_PARA=4 (strobes 45 cycles apart).
module tb_uart_frame_tx;

  localparam int unsigned BPS    = 4;
  localparam int          STRIDE = BPS * 11 + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic [31:0] frame_data = '0;
  logic        busy, frame_done, tx_data_valid;
  logic [7:0]  tx_data_in;

  uart_frame_tx #(.BPS_PARA(BPS), .HEADER(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .frame_data(frame_data),
    .busy(busy), .frame_done(frame_done), .tx_data_valid(tx_data_valid), .tx_data_in(tx_data_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [7:0] b;
    int         c;
  } exp_t;

  exp_t bq[$];
  int   dq[$];
  int   rq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Expected bytes, strobe cycles, done cycle and busy length for a frame accepted
  // at the posedge following monitor cycle c0.
  task automatic push_frame(input int c0, input logic [31:0] d, input int nbytes, input bit full);
    logic [7:0] b [6];
    b[0] = 8'hA5;
    b[1] = d[31:24];
    b[2] = d[23:16];
    b[3] = d[15:8];
    b[4] = d[7:0];
    b[5] = d[31:24] + d[23:16] + d[15:8] + d[7:0];
    for (int k = 0; k < nbytes; k++) begin
      exp_t e;
      e.b = b[k];
      e.c = c0 + 2 + k * STRIDE;
      bq.push_back(e);
    end
    if (full) begin
      dq.push_back(c0 + 2 + 6 * STRIDE);
      rq.push_back(6 * STRIDE + 1);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor
  logic [7:0] last_byte = '0;
  int         run = 0;
  always @(negedge clk) begin
    if (busy) run++;
    else if (run > 0) begin
      if (rq.size() == 0) chk("busy_unexpected_run", run, 0);
      else chk("busy_len", run, rq.pop_front());
      run = 0;
    end
    if (!rst_n) last_byte = '0;
    if (tx_data_valid) begin
      if (bq.size() == 0) chk("unexpected_strobe", {24'd0, tx_data_in}, 32'hFFFF_FFFF);
      else begin
        exp_t e;
        e = bq.pop_front();
        chk("strobe_byte", {24'd0, tx_data_in}, {24'd0, e.b});
        chk("strobe_cycle", cyc, e.c);
        last_byte = e.b;
      end
    end else if (tx_data_in !== last_byte) begin
      chk("byte_hold", {24'd0, tx_data_in}, {24'd0, last_byte});
    end
    if (frame_done) begin
      if (dq.size() == 0) chk("unexpected_done", cyc, 0);
      else chk("done_cycle", cyc, dq.pop_front());
      chk("busy_at_done", {31'd0, busy}, 1);
    end
  end

  task automatic send_frame(input logic [31:0] d);
    int c0;
    frame_data  = d;
    frame_start = 1'b1;
    c0 = cyc;
    push_frame(c0, d, 6, 1'b1);
    @(negedge clk);
    frame_start = 1'b0;
    wait_cyc(c0 + 2 + 6 * STRIDE + 10);
  endtask

  initial begin : stim
    int c0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, frame_done}, 0);
    chk("rst_valid", {31'd0, tx_data_valid}, 0);
    chk("rst_byte", {24'd0, tx_data_in}, 0);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    send_frame(32'h12345678);
    send_frame(32'h00000000);

    // Start pulse with new data while the frame is mid-flight must be ignored
    frame_data  = 32'h12345678;
    frame_start = 1'b1;
    c0 = cyc;
    push_frame(c0, 32'h12345678, 6, 1'b1);
    @(negedge clk);
    frame_start = 1'b0;
    wait_cyc(c0 + 2 + 2 * STRIDE + 5);
    frame_data  = 32'hDEADBEEF;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    wait_cyc(c0 + 2 + 6 * STRIDE + 60);

    // Reset during the gap after byte 3
    frame_data  = 32'h12345678;
    frame_start = 1'b1;
    c0 = cyc;
    push_frame(c0, 32'h12345678, 4, 1'b0);
    rq.push_back(3 * STRIDE + 11);
    @(negedge clk);
    frame_start = 1'b0;
    wait_cyc(c0 + 2 + 3 * STRIDE + 10);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_done", {31'd0, frame_done}, 0);
    chk("arst_valid", {31'd0, tx_data_valid}, 0);
    chk("arst_byte", {24'd0, tx_data_in}, 0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3 * STRIDE) @(negedge clk);
    send_frame(32'h12345678);

    // Held start: three back-to-back frames, 272 cycles apart
    frame_data  = 32'h01020304;
    frame_start = 1'b1;
    c0 = cyc;
    push_frame(c0, 32'h01020304, 6, 1'b1);
    push_frame(c0 + 6 * STRIDE + 2, 32'hAABBCCDD, 6, 1'b1);
    push_frame(c0 + 2 * (6 * STRIDE + 2), 32'hFFFFFFFF, 6, 1'b1);
    wait_cyc(c0 + 1);
    frame_data = 32'hAABBCCDD;
    wait_cyc(c0 + (6 * STRIDE + 2) + 2);
    frame_data = 32'hFFFFFFFF;
    wait_cyc(c0 + 2 * (6 * STRIDE + 2) + 10);
    frame_start = 1'b0;
    wait_cyc(c0 + 3 * (6 * STRIDE + 2) + 60);

    chk("bytes_left", bq.size(), 0);
    chk("dones_left", dq.size(), 0);
    chk("busy_runs_left", rq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_frame_tx.md
# uart_frame_tx

Frame-level UART transmit sequencer that drives the byte-level transmit side of `uart_bus`: `tx_data_valid` and `tx_data_in`. It accepts one 32-bit word and emits a 6-byte frame: header, four data bytes MSB first, then an 8-bit additive checksum. The byte transmitter has no ready signal, so this block paces bytes with its own byte-time counter derived from the same `BPS_PARA` as `uart_bus`. It sits between application logic and `uart_bus`.

## Interface
- `BPS_PARA`, 1250: clock cycles per UART bit. Must equal the `uart_bus` instance value; 1250 gives 9600 baud at 12 MHz.
- `HEADER`, 8'hA5: first byte of every frame.
- `clk` input 1: system clock, 12 MHz.
- `rst_n` input 1: asynchronous, active-low reset.
- `frame_start` input 1: request to send a frame; sampled on every rising clk edge.
- `frame_data` input 32: payload; latched in the cycle `frame_start` is accepted.
- `busy` output 1: a frame is in progress.
- `frame_done` output 1: one-cycle pulse when the frame completes.
- `tx_data_valid` output 1: one-cycle strobe to `uart_bus`.
- `tx_data_in` output 8: byte to `uart_bus`; stable whenever `tx_data_valid` is high.

## Operation
- BYTE_CYCLES = `BPS_PARA`*11 (10 frame bits plus 1 guard bit).
- Gap counter width is $clog2(BYTE_CYCLES); counts 0..BYTE_CYCLES-1.
- Byte index is 3 bits and runs 0..5.
- Byte order:
  - 0: `HEADER`
  - 1: data[31:24]
  - 2: data[23:16]
  - 3: data[15:8]
  - 4: data[7:0]
  - 5: checksum
- Checksum = (data[31:24]+data[23:16]+data[15:8]+data[7:0]) mod 256, computed from the latched word. Carries are discarded.
- FSM states:
  - IDLE: `busy`=0. If `frame_start`=1, latch `frame_data`, set index=0, go to SEND.
  - SEND: drive `tx_data_in`=byte[index] with `tx_data_valid`=1 for exactly one cycle, clear the gap counter, go to WAIT.
  - WAIT: increment the gap counter. When it reaches BYTE_CYCLES-1:
    - if index<5: index+1, go to SEND;
    - else go to DONE.
  - DONE: `frame_done`=1 for one cycle, go to IDLE.
- `frame_start` is ignored in SEND, WAIT and DONE. There is no queueing. `frame_data` changes after latching have no effect.
- `tx_data_in` holds the last sent byte between strobes and after the frame ends.
- Reset, including mid-frame: FSM to IDLE immediately (asynchronous). Counters and index are cleared. The current byte on the line is abandoned and no further strobes are issued.

## Timing
- Reset values:
  - `busy`=0, `frame_done`=0, `tx_data_valid`=0, `tx_data_in`=8'h00.
  - Internal latched word = 0.
- Let edge E0 be the edge at which `frame_start`=1 is sampled in IDLE.
  - `busy`=1 from the cycle after E0 through the DONE cycle inclusive.
  - Strobe k (k=0..5) is high in cycle 1 + k*(BYTE_CYCLES+1) after E0. Consecutive strobes are BYTE_CYCLES+1 cycles apart.
  - `frame_done` is high in cycle 1 + 6*(BYTE_CYCLES+1) after E0.
  - `busy` falls the cycle after `frame_done`.
- If `frame_start` is held high continuously, the next frame is accepted on the first IDLE edge. Its first strobe comes 2 cycles after `frame_done`.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- `BPS_PARA`=4 (BYTE_CYCLES=44), `frame_data`=32'h12345678, one-cycle start -> bytes A5,12,34,56,78,14 on six strobes 45 cycles apart; one `frame_done` pulse; `busy` high for 271 cycles.
- `frame_data`=32'hFFFFFFFF -> checksum byte 8'hFC (carry discarded); `frame_data`=0 -> bytes A5,00,00,00,00,00.
- `frame_start` pulsed during WAIT of byte 2, with `frame_data` changed to 32'hDEADBEEF -> ignored; current frame bytes unchanged; exactly six strobes total.
- `rst_n` asserted during WAIT of byte 3 -> all outputs return to reset values asynchronously; no further strobes. New start after release -> full frame from the header.
- `frame_start` held high for 3 frames -> exactly 18 strobes; each header follows the previous `frame_done` by 2 cycles.
- Loopback: connect to `uart_bus` with `BPS_PARA`=16, `uart_tx` wired to `uart_rx` -> `rx_data_out` sequence A5,12,34,56,78,14 with no lost or merged bytes.
